// File: rtl/load_input_unit.sv
// Load input unit: requests a block of words from a DMA read channel
// and streams the returned beats into a BRAM write port.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   conf_regs           [31:0] source word index, [95:64] length in words
//   start               one-cycle load request (honoured only when idle)
//   read_ctrl_*         DMA read request {size, length, index}
//   read_chnl_*         DMA read data beats
//   out_wr_en/addr/data BRAM write port, one cycle after each beat
//   done, busy          completion pulse, non-idle indicator
module load_input_unit #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DMA_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [95:0]               conf_regs,
    input  logic                      start,
    output logic                      read_ctrl_valid,
    input  logic                      read_ctrl_ready,
    output logic [66:0]               read_ctrl_data,
    input  logic                      read_chnl_valid,
    output logic                      read_chnl_ready,
    input  logic [DMA_DATA_WIDTH-1:0] read_chnl_data,
    output logic                      out_wr_en,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic [DMA_DATA_WIDTH-1:0] out_data,
    output logic                      done,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        SND_RD_REQ,
        RD_DATA,
        FINISH
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [31:0]           idx_q;
    logic [31:0]           len_q;
    logic [31:0]           cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  beat;
    logic                  unused_conf;

    assign unused_conf = ^conf_regs[63:32];
    assign beat        = read_chnl_valid & read_chnl_ready;

    always_comb begin
        state_nxt       = state;
        read_ctrl_valid = 1'b0;
        read_ctrl_data  = '0;
        read_chnl_ready = 1'b0;
        done            = 1'b0;
        busy            = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    // A zero-length load skips the DMA entirely.
                    if (conf_regs[95:64] != 32'd0)
                        state_nxt = SND_RD_REQ;
                    else
                        state_nxt = FINISH;
                end
            end
            SND_RD_REQ: begin
                read_ctrl_valid = 1'b1;
                read_ctrl_data  = {3'b001, len_q, idx_q};
                if (read_ctrl_ready)
                    state_nxt = RD_DATA;
            end
            RD_DATA: begin
                read_chnl_ready = 1'b1;
                if (read_chnl_valid && (cnt_q == len_q - 32'd1))
                    state_nxt = FINISH;
            end
            FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            out_wr_en <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            out_wr_en <= beat;
            if ((state == IDLE) && start) begin
                idx_q  <= conf_regs[31:0];
                len_q  <= conf_regs[95:64];
                cnt_q  <= '0;
                addr_q <= '0;
            end
            // Write address wraps silently at the BRAM depth.
            if (beat) begin
                out_addr <= addr_q;
                out_data <= read_chnl_data;
                addr_q   <= addr_q + 1'b1;
                cnt_q    <= cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: doc/load_input_unit.md
LOAD_INPUT_UNIT -- requirements
Module: load_input_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5: BRAM write address width.
REQ-002 SHALL have parameter DMA_DATA_WIDTH, default 32: DMA read channel and BRAM data width.
REQ-003 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port conf_regs, input, 96: [31:0] source word index, [95:64] transfer length in words, [63:32] unused.
REQ-006 SHALL have port start, input, 1: one-cycle request to begin a load.
REQ-007 SHALL have ports read_ctrl_valid (output, 1), read_ctrl_ready (input, 1) and read_ctrl_data (output, 67): DMA read request, packed as {size[2:0], length[31:0], index[31:0]}.
REQ-008 SHALL have ports read_chnl_valid (input, 1), read_chnl_ready (output, 1) and read_chnl_data (input, DMA_DATA_WIDTH): DMA read data beats.
REQ-009 SHALL have ports out_wr_en (output, 1), out_addr (output, ADDR_WIDTH) and out_data (output, DMA_DATA_WIDTH): BRAM write port.
REQ-010 SHALL have ports done (output, 1), a one-cycle completion pulse, and busy (output, 1), high in any state other than IDLE.

Function
REQ-011 SHALL implement states IDLE, SND_RD_REQ, RD_DATA and FINISH.
REQ-012 In IDLE, start=1 SHALL latch conf_regs index and length into internal registers and clear the beat counter and write address.
REQ-013 From IDLE on start: latched length nonzero -> SND_RD_REQ; length zero -> FINISH, with no DMA request issued.
REQ-014 start SHALL be ignored in every state except IDLE; latched config SHALL NOT change while busy.
REQ-015 In SND_RD_REQ, read_ctrl_valid=1 and read_ctrl_data={3'b001, latched length, latched index}; size 3'b001 denotes 32-bit words.
REQ-016 read_ctrl_valid and read_ctrl_data SHALL stay stable until read_ctrl_ready=1; on that cycle the FSM SHALL move to RD_DATA.
REQ-017 Outside SND_RD_REQ, read_ctrl_valid=0 and read_ctrl_data=0.
REQ-018 read_chnl_ready SHALL be 1 only in RD_DATA; a beat is accepted when read_chnl_valid & read_chnl_ready.
REQ-019 On each accepted beat, the next cycle SHALL drive out_wr_en=1, out_data=accepted data and out_addr=write address at acceptance; latency is 1 cycle, with no backpressure from the BRAM.
REQ-020 out_wr_en SHALL be 0 in every cycle not immediately following an accepted beat; out_addr and out_data hold their last value.
REQ-021 The write address SHALL increment by 1 per accepted beat, modulo 2^ADDR_WIDTH: 31 -> 0 at the default width, with no error flagged.
REQ-022 The 32-bit beat counter SHALL increment per accepted beat; acceptance with count == length-1 SHALL move the FSM to FINISH.
REQ-023 Beats presented while read_chnl_ready=0 SHALL NOT be consumed or written.
REQ-024 FINISH SHALL last exactly 1 cycle with done=1, then return to IDLE; done=0 in all other states.
REQ-025 For a nonzero length, done SHALL assert in the same cycle as the out_wr_en of the final beat.
REQ-026 A start arriving in the FINISH cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-027 rst=0 at a clock edge SHALL force IDLE from any state and clear counter, address and latched config.
REQ-028 The first cycle after rst SHALL show read_ctrl_valid=0, read_ctrl_data=0, read_chnl_ready=0, out_wr_en=0, out_addr=0, out_data=0, done=0, busy=0.
REQ-029 A reset mid-transfer SHALL abandon the transfer: no done pulse, and later beats are ignored until a new start.

Verification
REQ-030 Length 4, index 0x100, ctrl ready after 3 cycles, beats 0xA0..0xA3 back-to-back -> read_ctrl_data={3'b001,32'd4,32'h100}; writes to addr 0..3 with data A0..A3; done coincides with the addr-3 write; 4 writes total.
REQ-031 Length 3 with read_chnl_valid toggling 1,0,1,0,1 -> exactly 3 writes at addr 0,1,2; data follows only the accepted beats.
REQ-032 Length 34 at ADDR_WIDTH 5 -> beats 33 and 34 are written to addr 0 and 1; done after the 34th beat.
REQ-033 Length 0 -> no read_ctrl_valid; busy high for 1 cycle; done pulses 1 cycle after start.
REQ-034 Length 8, rst=0 after the 5th beat -> all outputs at reset values the next cycle, no done, and a subsequent start of length 2 completes normally from addr 0.
REQ-035 start pulsed during RD_DATA and in the FINISH cycle with different conf_regs -> current transfer unaffected, no second request issued.
